// File: rtl/key_pkg.sv
// Shared types and default constants for the key debouncer slice.
// Ports: none (package only).
// Provides the per-channel FSM state type and a counter-width helper.
package key_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } key_state_t;

    // 20 ms and 1 s at a 50 MHz clock.
    localparam int KEY_DEBOUNCE_DEFAULT = 1000000;
    localparam int KEY_LONG_DEFAULT     = 50000000;

    // Debounce counter width: $clog2(n), never below one bit.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/key_debouncer_if.sv
// Bundles the raw key pins and the conditioned key outputs.
// Ports: key_raw (pins), key_level / key_press / key_release / key_long.
// master = the side that owns the pins and consumes events; slave = the debouncer.
interface key_debouncer_if #(
    parameter int NKEYS = 3
);
    logic [NKEYS-1:0] key_raw;
    logic [NKEYS-1:0] key_level;
    logic [NKEYS-1:0] key_press;
    logic [NKEYS-1:0] key_release;
    logic [NKEYS-1:0] key_long;

    modport master (
        output key_raw,
        input  key_level, key_press, key_release, key_long
    );

    modport slave (
        input  key_raw,
        output key_level, key_press, key_release, key_long
    );
endinterface

// File: rtl/key_debounce_ch.sv
// One key channel: 2-FF synchronizer, debounce FSM, optional hold counter.
// Ports: clk, rst (async active-high), key_raw in; key_level/key_press/key_release/key_long out.
// Long-press strobe is built only when KEY_DEBOUNCE_LONGPRESS_EN is defined; otherwise key_long is 0.
module key_debounce_ch
    import key_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = KEY_DEBOUNCE_DEFAULT,
    parameter int LONG_CYCLES     = KEY_LONG_DEFAULT,
    parameter bit ACTIVE_LOW      = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic key_raw,
    output logic key_level,
    output logic key_press,
    output logic key_release,
    output logic key_long
);

    localparam int             CW       = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 1 || LONG_CYCLES < 1) begin : g_bad_param
        $error("key_debounce_ch: DEBOUNCE_CYCLES and LONG_CYCLES must be >= 1");
    end

    logic        sync1, sync2, p;
    key_state_t  state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic        level_d, press_d, release_d;

    // Synchronizer resets to the released pin level so reset never looks like a press.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= ACTIVE_LOW;
            sync2 <= ACTIVE_LOW;
        end else begin
            sync1 <= key_raw;
            sync2 <= sync1;
        end
    end

    assign p = sync2 ^ ACTIVE_LOW;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            key_level   <= 1'b0;
            key_press   <= 1'b0;
            key_release <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            key_level   <= level_d;
            key_press   <= press_d;
            key_release <= release_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        level_d   = key_level;
        press_d   = 1'b0;
        release_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (p) begin
                    state_d = PRESS_WAIT;
                    cnt_d   = '0;
                end
            end
            PRESS_WAIT: begin
                if (!p) begin
                    state_d = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = PRESSED;
                    level_d = 1'b1;
                    press_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            PRESSED: begin
                if (!p) begin
                    state_d = RELEASE_WAIT;
                    cnt_d   = '0;
                end
            end
            RELEASE_WAIT: begin
                if (p) begin
                    state_d = PRESSED;
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = IDLE;
                    level_d   = 1'b0;
                    release_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef KEY_DEBOUNCE_LONGPRESS_EN
    localparam int             HW        = $clog2(LONG_CYCLES + 1);
    localparam logic [HW-1:0]  HOLD_LAST = HW'(LONG_CYCLES - 1);
    localparam logic [HW-1:0]  HOLD_MAX  = HW'(LONG_CYCLES);

    logic [HW-1:0] hold_q;
    logic          held;

    assign held = (state_q == PRESSED) || (state_q == RELEASE_WAIT);

    // Cleared only on the genuine PRESS_WAIT->PRESSED entry: a release bounce
    // back into PRESSED is the same press and must not re-arm key_long.
    // Saturating at LONG_CYCLES makes the HOLD_LAST match fire once per press.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_q   <= '0;
            key_long <= 1'b0;
        end else begin
            key_long <= held && (hold_q == HOLD_LAST);
            if (state_q == PRESS_WAIT && state_d == PRESSED) begin
                hold_q <= '0;
            end else if (state_d == IDLE) begin
                hold_q <= '0;
            end else if (held && hold_q != HOLD_MAX) begin
                hold_q <= hold_q + 1'b1;
            end
        end
    end
`else
    assign key_long = 1'b0;
`endif

endmodule

// File: rtl/key_debouncer.sv
// Multi-key debouncer: NKEYS independent channels of sync + debounce FSM.
// Ports: clk, rst (async active-high), kif (slave: key_raw in; level/press/release/long out).
// Optional long-press strobe enabled by KEY_DEBOUNCE_LONGPRESS_EN; all outputs registered.
module key_debouncer
    import key_pkg::*;
#(
    parameter int NKEYS           = 3,
    parameter int DEBOUNCE_CYCLES = KEY_DEBOUNCE_DEFAULT,
    parameter int LONG_CYCLES     = KEY_LONG_DEFAULT,
    parameter bit ACTIVE_LOW      = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    key_debouncer_if.slave   kif
);

    wire [NKEYS-1:0] level_w;
    wire [NKEYS-1:0] press_w;
    wire [NKEYS-1:0] release_w;
    wire [NKEYS-1:0] long_w;

    for (genvar gi = 0; gi < NKEYS; gi++) begin : g_ch
        key_debounce_ch #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .LONG_CYCLES     (LONG_CYCLES),
            .ACTIVE_LOW      (ACTIVE_LOW)
        ) u_ch (
            .clk         (clk),
            .rst         (rst),
            .key_raw     (kif.key_raw[gi]),
            .key_level   (level_w[gi]),
            .key_press   (press_w[gi]),
            .key_release (release_w[gi]),
            .key_long    (long_w[gi])
        );
    end

    assign kif.key_level   = level_w;
    assign kif.key_press   = press_w;
    assign kif.key_release = release_w;
    assign kif.key_long    = long_w;

endmodule

// File: doc/key_debouncer.md
# key_debouncer

Front-end conditioning stage for the board push-buttons: it synchronises each raw key input to `clk`, filters contact bounce with a per-key stability counter, and presents clean active-high press levels plus single-cycle press/release strobes. It sits directly between the key pins and the LED/buzzer control logic, which then consumes `key_press` directly instead of raw key edges.

## Interface
- `NKEYS`, 3: number of independent key channels.
- `DEBOUNCE_CYCLES`, 1000000: stable cycles required before a change is accepted (20 ms at 50 MHz); must be ≥1.
- `LONG_CYCLES`, 50000000: held cycles before a long-press strobe (1 s at 50 MHz); must be ≥1.
- `ACTIVE_LOW`, 1: 1 = raw pin reads 0 when pressed; 0 = reads 1 when pressed.
- `clk`  in  1  system clock; all state updates on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `key_raw`  in  NKEYS  unsynchronised key pins.
- `key_level`  out  NKEYS  debounced state; 1 = pressed.
- `key_press`  out  NKEYS  one-cycle strobe on accepted press.
- `key_release`  out  NKEYS  one-cycle strobe on accepted release.
- `key_long`  out  NKEYS  one-cycle strobe when a press has been held for `LONG_CYCLES` cycles (see Configuration).

## Operation
- Per channel: 2-FF synchronizer, then normalisation `p = s2 ^ ACTIVE_LOW`, so `p` = 1 when the key is pressed.
- FSM per channel, with counter `cnt` of width `$clog2(DEBOUNCE_CYCLES)` (minimum 1):
  - `IDLE`: when `p`=1, go to `PRESS_WAIT` and set `cnt`=0.
  - `PRESS_WAIT`: when `p`=0, return to `IDLE` (bounce). Otherwise, if `cnt`==`DEBOUNCE_CYCLES`-1, go to `PRESSED`, set `key_level`=1 and strobe `key_press`. Otherwise increment `cnt`.
  - `PRESSED`: when `p`=0, go to `RELEASE_WAIT` and set `cnt`=0.
  - `RELEASE_WAIT`: when `p`=1, return to `PRESSED`. Otherwise, if `cnt`==`DEBOUNCE_CYCLES`-1, go to `IDLE`, set `key_level`=0 and strobe `key_release`. Otherwise increment `cnt`.
- Any bounce during a WAIT state discards progress. The next qualifying transition restarts `cnt` at 0.
- Channels are fully independent. Strobes on several channels in the same cycle are legal.
- All outputs are registered. Each strobe is high for exactly one cycle per accepted event.

## Timing
- Reset values: `key_level`, `key_press`, `key_release` and `key_long` are all 0. All FSMs are in `IDLE`. All counters are 0. Synchronizer flops are set to the released pin level (`ACTIVE_LOW`).
- Press latency: take a raw press that is stable from edge k, where edge k is the first edge that samples it. `key_press` and the rising `key_level` are visible after edge k+`DEBOUNCE_CYCLES`+2.
- Release latency is symmetric: `key_release` is visible after edge k+`DEBOUNCE_CYCLES`+2.
- Reset asserted mid-press or mid-wait: everything returns to the reset values immediately. If the key is still held when `rst` is released, a fresh press is reported after the full latency.
- Glitch rule: a pulse shorter than `DEBOUNCE_CYCLES`+1 synchronised cycles never produces a strobe.

## Configuration
- Macro: `KEY_DEBOUNCE_LONGPRESS_EN`.
- Defined:
  - Each channel has a hold counter of width `$clog2(LONG_CYCLES+1)`, cleared on entry to `PRESSED`.
  - The counter increments while in `PRESSED` or `RELEASE_WAIT`, and saturates.
  - `key_long` pulses once when the counter reaches `LONG_CYCLES`-1, and never again in the same press.
  - The counter is cleared when the channel returns to `IDLE`.
- Not defined: the hold counter is not built, and `key_long` is tied to 0. The port remains present.

## Structure
- Package `key_pkg`:
  - State enum typedef `key_state_t`: `IDLE`, `PRESS_WAIT`, `PRESSED`, `RELEASE_WAIT`.
  - Default constants `KEY_DEBOUNCE_DEFAULT` and `KEY_LONG_DEFAULT`.
- Sub-module `key_debounce_ch`: one channel, containing the synchronizer, FSM and counters. The top instantiates it `NKEYS` times in a generate loop.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4, `LONG_CYCLES`=10 and `ACTIVE_LOW`=1.
- Clean press: `key_raw[0]` goes 1→0 and is sampled at edge 0. Required: `key_press[0]` is high for exactly the one cycle after edge 6, `key_level[0]` is 1 from edge 6, and no other channel toggles.
- Bounce: `key_raw[1]` toggles 0,1,0,1 on consecutive cycles, then holds 0. Required: exactly one `key_press[1]`, 7 edges after the final stable sample.
- Release and glitch: hold key 2 pressed, then release it with a 3-cycle high glitch. Required: no `key_release`. After a clean release, exactly one `key_release[2]` strobe and `key_level[2]`=0.
- Simultaneous keys: all three keys are pressed on the same edge. Required: all three `key_press` bits pulse in the same cycle.
- Reset mid-wait: assert `rst` 2 cycles into `PRESS_WAIT` with the key still held. Required: outputs go to 0 immediately, and `key_press` follows 7 edges after reset deassertion.
- Long press, with the macro defined: hold key 0 for 20 cycles after `key_press`. Required: exactly one `key_long[0]` pulse, 10 cycles after `key_press`. With the macro undefined, `key_long` stays 0.
